// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: byte-mask/store-data alignment plus an address/data bus handshake FSM.
// Optional MEM_ADDR_EXC_EN: misaligned half/word accesses raise adel_o/ades_o instead of reaching the bus.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [2:0]  ls_type,
    input  logic [3:0]  load_type_i,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        data_req,
    output logic        data_wr,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        stall_o,
    output logic        resp_valid,
    output logic [31:0] mem_rdata_o,
    output logic [3:0]  byte_valid_o,
    output logic [3:0]  load_type_o,
    output logic        adel_o,
    output logic        ades_o
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, DROP, RESP} state_t;

    state_t      state, state_nxt;
    logic [1:0]  a;
    logic [3:0]  mask;
    logic [31:0] wdata_al;
    logic        err;
    logic        accept;
    logic        capture;
    logic        req_live;

    assign a = req_addr[1:0];

    always_comb begin
        mask     = 4'b1111;
        wdata_al = req_wdata;
        case (ls_type)
            3'd0: begin
                mask     = 4'b0001 << a;
                wdata_al = {4{req_wdata[7:0]}};
            end
            3'd1: begin
                mask     = a[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{req_wdata[15:0]}};
            end
            3'd3: begin
                mask     = 4'b1111 >> (2'd3 - a);
                wdata_al = req_wdata >> {(2'd3 - a), 3'b000};
            end
            3'd4: begin
                mask     = 4'b1111 << a;
                wdata_al = req_wdata << {a, 3'b000};
            end
            default: begin
                mask     = 4'b1111;
                wdata_al = req_wdata;
            end
        endcase
    end

`ifdef MEM_ADDR_EXC_EN
    always_comb begin
        err = 1'b0;
        case (ls_type)
            3'd0, 3'd3, 3'd4: err = 1'b0;
            3'd1:             err = a[0];
            default:          err = (a != 2'd0);
        endcase
    end
`else
    assign err = 1'b0;
`endif

    assign req_live = (state == IDLE) && req_valid && !flush;
    assign accept   = req_live && !err;

    // Read data is captured on the data_ok that leads into RESP.
    assign capture  = ((state == ADDR) && data_addr_ok && data_data_ok && !flush) ||
                      ((state == DATA) && data_data_ok && !flush);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = ADDR;
            ADDR: begin
                if (data_addr_ok) begin
                    if (data_data_ok) state_nxt = flush ? IDLE : RESP;
                    else              state_nxt = flush ? DROP : DATA;
                end else if (flush) begin
                    state_nxt = IDLE;
                end
            end
            DATA: begin
                if (data_data_ok) state_nxt = flush ? IDLE : RESP;
                else if (flush)   state_nxt = DROP;
            end
            DROP: if (data_data_ok) state_nxt = IDLE;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        data_req   = (state == ADDR);
        resp_valid = (state == RESP);
        stall_o    = accept || (state == ADDR) || (state == DATA) || (state == DROP);
`ifdef MEM_ADDR_EXC_EN
        adel_o     = req_live && err && !req_wr;
        ades_o     = req_live && err && req_wr;
`else
        adel_o     = 1'b0;
        ades_o     = 1'b0;
`endif
    end

    // Bus fields are latched on accept and stay frozen until the next accept.
    logic [3:0] lt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_wr    <= 1'b0;
            data_addr  <= 32'h0;
            data_wstrb <= 4'h0;
            data_wdata <= 32'h0;
            lt_q       <= 4'h0;
        end else if (accept) begin
            data_wr    <= req_wr;
            data_addr  <= {req_addr[31:2], 2'b00};
            data_wstrb <= mask;
            data_wdata <= wdata_al;
            lt_q       <= load_type_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rdata_o  <= 32'h0;
            byte_valid_o <= 4'h0;
            load_type_o  <= 4'h0;
        end else if (capture) begin
            mem_rdata_o  <= data_rdata;
            byte_valid_o <= data_wstrb;
            load_type_o  <= lt_q;
        end
    end

endmodule
